firmware_loader: RTL
====================

Name: firmware_loader

Overview:
- Byte-stream writer for the instruction/data memory image: receives a length-prefixed little-endian firmware stream over a valid/ready byte interface.
- Assembles the bytes into 32-bit words and issues single-cycle word writes to a memory write port.
- Sits between the host byte link (UART receiver) and the memory's write side. The CPU is held off via busy until the image is complete.

Parameters:
- SIZE, 1024, memory capacity in 32-bit words; larger length headers are rejected.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  one-cycle word write strobe
- mem_addr  output  32  byte address of write, word-aligned
- mem_wdata  output  32  write data
- busy  output  1  load in progress
- done  output  1  last load completed successfully (level)
- error  output  1  last load aborted (level)

Behaviour:
- Reset state: IDLE. in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0. Byte counter, word counter and length are all cleared.
- Reset asserted mid-load returns to IDLE on the same edge. A partial word is discarded and no further writes occur.
- Handshake: a byte transfers on a cycle with in_valid && in_ready. in_ready=1 exactly in states LEN, DATA and CSUM, registered, with no other backpressure. in_data is ignored when no transfer occurs.
- States and transitions:
  - IDLE/DONE/ERR + start -> LEN. Clears done, error, counters and the checksum accumulator. Sets busy.
  - LEN: 4 bytes, little-endian, form the 32-bit word count N. After the 4th byte:
    - N==0 -> DONE (or CSUM if enabled).
    - N>SIZE -> ERR, with no memory writes.
    - otherwise -> DATA.
  - DATA: bytes are shifted into a word buffer, little-endian (byte 0 -> bits 7:0).
    - On acceptance of byte 3 of word k: on the next cycle mem_we=1, mem_addr=BASE_ADDR+4*k, mem_wdata=assembled word.
    - mem_we is high for exactly one cycle; mem_addr/mem_wdata hold their values afterwards until the next write.
    - A byte may be accepted in the same cycle mem_we pulses; there is no stall.
    - After byte 3 of word N-1 -> DONE (or CSUM). The final mem_we pulse occurs in the first cycle of that next state.
  - DONE: busy=0, done=1, in_ready=0.
  - ERR: busy=0, error=1, in_ready=0.
- start while in LEN/DATA/CSUM is ignored. start in the same cycle as rst: rst wins.
- Word counter is 31 bits, so N==SIZE writes through word SIZE-1 with no wrap. Address arithmetic is modulo 2^32.
- done and error are never both 1.

Optional Feature:
- Macro: FIRMWARE_LOADER_CHECKSUM_EN.
- Enabled:
  - A running 8-bit XOR of every payload byte (DATA bytes only, not LEN) is kept.
  - After the last payload byte (or after LEN when N==0), the state is CSUM.
  - One byte is accepted in CSUM. If it equals the XOR -> DONE, otherwise -> ERR.
  - Data words are already written regardless of the checksum result.
  - N>SIZE still goes directly to ERR with no CSUM byte consumed.
- Disabled: the CSUM state, the accumulator and the extra byte do not exist. The stream ends after the last payload byte.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, in_ready=0. With in_valid=1 in_data=8'hAA held, no transfers occur.
- start, stream 02 00 00 00 | 13 00 00 00 | 37 01 00 00 with in_valid continuously high -> exactly two mem_we pulses: addr 0x0 data 0x00000013, then addr 0x4 data 0x00000137. done=1 the cycle of the second pulse, busy=0.
- BASE_ADDR=32'h100, N=1, bytes EF BE AD DE with in_valid toggling 1/0 each cycle -> one write at addr 0x100 with data 0xDEADBEEF, issued exactly one cycle after the 4th accepted byte.
- SIZE=4, header 05 00 00 00 -> error=1 after the 4th byte, no mem_we ever. A subsequent start with N=0 gives done=1, error=0.
- rst pulsed after 6 payload bytes of an N=3 load -> exactly 1 write seen, then IDLE with all outputs at reset values. A fresh start with N=1 writes at BASE_ADDR.
- With FIRMWARE_LOADER_CHECKSUM_EN, N=1 payload 01 02 04 08:
  - checksum 0F -> done=1.
  - checksum 0E -> error=1, and the word 0x08040201 is still written once.

Source files
------------

// File: rtl/firmware_loader_if.sv
`default_nettype none
// ============================================================================
// firmware_loader_if : byte-stream input, memory write port and status bundle
// Rev 1.0
// ============================================================================
interface firmware_loader_if;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        error;

   // master: host side driving the stream; slave: the loader itself
   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
   );
endinterface
`default_nettype wire

// File: rtl/firmware_loader.sv
`default_nettype none
// ============================================================================
// firmware_loader : length-prefixed LE byte stream -> 32-bit memory word writes
// Optional trailing XOR checksum byte: FIRMWARE_LOADER_CHECKSUM_EN.  Rev 1.0
// ============================================================================
module firmware_loader #(
   parameter int unsigned SIZE      = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  wire logic        clk,
   input  wire logic        rst,
   firmware_loader_if.slave bus
);

   localparam logic [31:0] SIZE_WORDS = 32'(SIZE);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

`ifdef FIRMWARE_LOADER_CHECKSUM_EN
   localparam state_t S_PAYLOAD_END = S_CSUM;
`else
   localparam state_t S_PAYLOAD_END = S_DONE;
`endif

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [30:0] word_cnt_q, word_cnt_d;
   logic [31:0] len_q, len_d;
   logic [31:0] buf_q, buf_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        active_q, active_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif
   logic        xfer;

   assign xfer = bus.in_valid && active_q;

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_cnt_d  = word_cnt_q;
      len_d       = len_q;
      buf_d       = buf_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
               state_d    = S_LEN;
               byte_cnt_d = '0;
               word_cnt_d = '0;
               len_d      = '0;
               buf_d      = '0;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         S_LEN: begin
            if (xfer) begin
               len_d      = {bus.in_data, len_q[31:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (len_d == '0)
                     state_d = S_PAYLOAD_END;
                  else if (len_d > SIZE_WORDS)
                     state_d = S_ERR;
                  else
                     state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               buf_d      = {bus.in_data, buf_q[31:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ bus.in_data;
`endif
               // Word complete: strobe the write on the following cycle
               if (byte_cnt_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = BASE_ADDR + {word_cnt_q[29:0], 2'b00};
                  mem_wdata_d = buf_d;
                  word_cnt_d  = word_cnt_q + 31'd1;
                  if ({1'b0, word_cnt_d} == len_q)
                     state_d = S_PAYLOAD_END;
               end
            end
         end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer)
               state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      active_d = (state_d == S_LEN) || (state_d == S_DATA)
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
      done_d  = (state_d == S_DONE);
      error_d = (state_d == S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         byte_cnt_q  <= '0;
         word_cnt_q  <= '0;
         len_q       <= '0;
         buf_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_cnt_q  <= word_cnt_d;
         len_q       <= len_d;
         buf_q       <= buf_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         active_q    <= active_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.in_ready  = active_q;
   assign bus.busy      = active_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
